// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the CPU bridge bus.
// Word registers: CTRL (Addr 0), PRESET (Addr 1), COUNT (Addr 2, read-only).
// COUNT is loaded from PRESET, counts down to zero and then raises an interrupt:
// a level held until the next CTRL write (one-shot) or a one-cycle pulse per
// period (auto-reload).
module timer_dev #(
    parameter int CNT_WIDTH      = 32,
    parameter int AUTO_RELOAD_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [3:0]  Byte_sel,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    // CTRL[0]=Enable, CTRL[2:1]=Mode, CTRL[3]=IM; upper bits do not exist
    state_t                 r_state;
    logic [3:0]             r_ctrl;
    logic [CNT_WIDTH-1:0]   r_preset;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_irq_pend;
    logic                   r_irq;

    state_t                 w_state_nxt;
    logic [3:0]             w_ctrl_nxt;
    logic [CNT_WIDTH-1:0]   w_preset_nxt;
    logic [CNT_WIDTH-1:0]   w_count_nxt;
    logic                   w_pend_nxt;
    logic                   w_irq_nxt;
    logic                   w_ctrl_wr;
    logic                   w_preset_wr;
    logic                   w_auto;
    logic                   w_auto_nxt;
    logic [31:0]            w_preset_wide;

    assign w_ctrl_wr   = We && (Addr == A_CTRL);
    assign w_preset_wr = We && (Addr == A_PRESET);

    // Mode 1x and a build without auto-reload both fall back to one-shot
    assign w_auto     = (AUTO_RELOAD_EN != 0) && (r_ctrl[2:1] == 2'b01);
    assign w_auto_nxt = (AUTO_RELOAD_EN != 0) && (w_ctrl_nxt[2:1] == 2'b01);

    assign IRQ = r_irq;

    // Byte-merge of a PRESET write; bytes above CNT_WIDTH fall off on truncation
    always_comb begin
        w_preset_wide = 32'(r_preset);
        for (int i = 0; i < 4; i++) begin
            if (Byte_sel[i]) begin
                w_preset_wide[8*i +: 8] = DataIn[8*i +: 8];
            end
        end
        w_preset_nxt = w_preset_wr ? w_preset_wide[CNT_WIDTH-1:0] : r_preset;
    end

    // Next state, counter and CTRL/irq_pend; a CPU CTRL write overrides the FSM
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ctrl_nxt  = r_ctrl;
        w_pend_nxt  = r_irq_pend;

        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > CNT_WIDTH'(1)) begin
                    w_count_nxt = r_count - CNT_WIDTH'(1);
                end else begin
                    w_count_nxt = '0;
                    w_pend_nxt  = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_auto) begin
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_ctrl_nxt[0] = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_ctrl_wr) begin
            w_pend_nxt = 1'b0;
            if (Byte_sel[0]) begin
                w_ctrl_nxt = DataIn[3:0];
            end
        end

        // IRQ is registered from next-cycle values so it rises together with INT
        w_irq_nxt = w_ctrl_nxt[3] & (w_auto_nxt ? (w_state_nxt == S_INT) : w_pend_nxt);
    end

    // Register update with synchronous active-low reset overriding any write
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_pend <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_pend <= w_pend_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    // Read mux, no side effects; unmapped word reads zero
    always_comb begin
        case (Addr)
            A_CTRL:   DataOut = {28'd0, r_ctrl};
            A_PRESET: DataOut = 32'(r_preset);
            A_COUNT:  DataOut = 32'(r_count);
            default:  DataOut = 32'd0;
        endcase
    end

endmodule
